// File: rtl/sr_pulse_encoder.sv
// sr_pulse_encoder: turns an asynchronous, possibly bouncy level into a debounced
// level (Q/Qb) plus one-cycle set/reset pulses (S/R) and a count of rising events.
// Synchronizer, debounce FSM and event counter all run on clk.
module sr_pulse_encoder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned EV_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            I,
  input  logic            En,
  output logic            Q,
  output logic            Qb,
  output logic            S,
  output logic            R,
  output logic [EV_W-1:0] Ev_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  // Last count value before a qualification completes.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EV_W-1:0]  EV_ONE   = EV_W'(1);

  typedef enum logic [1:0] {
    StIdleLo,
    StQualHi,
    StIdleHi,
    StQualLo
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   i_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   q_q;
  logic                   s_q;
  logic                   r_q;
  logic [EV_W-1:0]        ev_q;

  // Synchronizer chain; keeps shifting regardless of En.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
    end
  end

  assign i_s = sync_q[SYNC_STAGES-1];

  // Debounce FSM with registered level, pulses and rising-event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdleLo;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ev_q    <= '0;
    end else begin
      // Pulses last exactly one cycle.
      s_q <= 1'b0;
      r_q <= 1'b0;
      unique case (state_q)
        StIdleLo: begin
          cnt_q <= '0;
          if (i_s && En) begin
            if (DEBOUNCE_CYC == 1) begin
              state_q <= StIdleHi;
              q_q     <= 1'b1;
              s_q     <= 1'b1;
              ev_q    <= ev_q + EV_ONE;
            end else begin
              state_q <= StQualHi;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        StQualHi: begin
          if (i_s && En) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= StIdleHi;
              cnt_q   <= '0;
              q_q     <= 1'b1;
              s_q     <= 1'b1;
              ev_q    <= ev_q + EV_ONE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            // Bounce or disable aborts the qualification silently.
            state_q <= StIdleLo;
            cnt_q   <= '0;
          end
        end
        StIdleHi: begin
          cnt_q <= '0;
          if (!i_s && En) begin
            if (DEBOUNCE_CYC == 1) begin
              state_q <= StIdleLo;
              q_q     <= 1'b0;
              r_q     <= 1'b1;
            end else begin
              state_q <= StQualLo;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        StQualLo: begin
          if (!i_s && En) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= StIdleLo;
              cnt_q   <= '0;
              q_q     <= 1'b0;
              r_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            state_q <= StIdleHi;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdleLo;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign Q      = q_q;
  assign Qb     = ~q_q;
  assign S      = s_q;
  assign R      = r_q;
  assign Ev_cnt = ev_q;

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// Directed bench for sr_pulse_encoder: default instance, a 2-bit counter instance for
// wrap/reset-abort, and a DEBOUNCE_CYC=1 / SYNC_STAGES=3 instance for the direct path.
module tb_sr_pulse_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance.
  logic       rst, i_a, en_a;
  logic       q_a, qb_a, s_a, r_a;
  logic [7:0] ev_a;

  // EV_W=2 instance.
  logic       rst_b, i_b, en_b;
  logic       q_b, qb_b, s_b, r_b;
  logic [1:0] ev_b;

  // DEBOUNCE_CYC=1, SYNC_STAGES=3 instance (shares rst with the default one).
  logic       i_c, en_c;
  logic       q_c, qb_c, s_c, r_c;
  logic [7:0] ev_c;

  sr_pulse_encoder dut (
    .clk(clk), .rst(rst), .I(i_a), .En(en_a),
    .Q(q_a), .Qb(qb_a), .S(s_a), .R(r_a), .Ev_cnt(ev_a)
  );

  sr_pulse_encoder #(.EV_W(2)) dut_w (
    .clk(clk), .rst(rst_b), .I(i_b), .En(en_b),
    .Q(q_b), .Qb(qb_b), .S(s_b), .R(r_b), .Ev_cnt(ev_b)
  );

  sr_pulse_encoder #(.SYNC_STAGES(3), .DEBOUNCE_CYC(1)) dut_f (
    .clk(clk), .rst(rst), .I(i_c), .En(en_c),
    .Q(q_c), .Qb(qb_c), .S(s_c), .R(r_c), .Ev_cnt(ev_c)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    i_a = 1'b0; en_a = 1'b1;
    i_b = 1'b0; en_b = 1'b1;
    i_c = 1'b0; en_c = 1'b1;
    repeat (3) tick();
    rst = 1'b0; rst_b = 1'b0;
    tick();
    total++;
    if ({q_a, qb_a, s_a, r_a} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_outs got QQbSR=%b want=0100", {q_a, qb_a, s_a, r_a});
    end
    total++;
    if (ev_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_ev got=%0d want=0", ev_a);
    end
    total++;
    if ({q_b, qb_b, ev_b} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_w got QQbEv=%b want=0100", {q_b, qb_b, ev_b});
    end
  endtask

  // Rising edge: S and Q update on edge 6 after the input changes.
  task automatic test_rise();
    i_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (s_a !== (k == 6)) begin
        bad++;
        $display("FAIL rise_s edge=%0d got=%b want=%b", k, s_a, (k == 6));
      end
      total++;
      if (q_a !== (k >= 6) || qb_a !== (k < 6)) begin
        bad++;
        $display("FAIL rise_q edge=%0d got Q=%b Qb=%b want Q=%b", k, q_a, qb_a, (k >= 6));
      end
    end
    total++;
    if (ev_a !== 8'd1) begin
      bad++;
      $display("FAIL rise_ev got=%0d want=1", ev_a);
    end
  endtask

  // Three-cycle low glitch while Q=1 must be rejected.
  task automatic test_glitch();
    i_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) i_a = 1'b1;
      total++;
      if (r_a !== 1'b0 || q_a !== 1'b1) begin
        bad++;
        $display("FAIL glitch edge=%0d got R=%b Q=%b want R=0 Q=1", k, r_a, q_a);
      end
    end
  endtask

  // Falling edge: R on edge 6, counter untouched. Exact edge also proves the glitch left cnt at 0.
  task automatic test_fall();
    i_a = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (r_a !== (k == 6) || s_a !== 1'b0) begin
        bad++;
        $display("FAIL fall_rs edge=%0d got R=%b S=%b want R=%b S=0", k, r_a, s_a, (k == 6));
      end
      total++;
      if (q_a !== (k < 6)) begin
        bad++;
        $display("FAIL fall_q edge=%0d got=%b want=%b", k, q_a, (k < 6));
      end
    end
    total++;
    if (ev_a !== 8'd1) begin
      bad++;
      $display("FAIL fall_ev got=%0d want=1", ev_a);
    end
  endtask

  // En low freezes; S fires DEBOUNCE_CYC edges after En returns.
  task automatic test_enable();
    en_a = 1'b0;
    i_a  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (s_a !== 1'b0 || q_a !== 1'b0) begin
        bad++;
        $display("FAIL en_hold edge=%0d got S=%b Q=%b want 0 0", k, s_a, q_a);
      end
    end
    en_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (s_a !== (k == 4) || q_a !== (k >= 4)) begin
        bad++;
        $display("FAIL en_rise edge=%0d got S=%b Q=%b want S=%b Q=%b",
                 k, s_a, q_a, (k == 4), (k >= 4));
      end
    end
    total++;
    if (ev_a !== 8'd2) begin
      bad++;
      $display("FAIL en_ev got=%0d want=2", ev_a);
    end
  endtask

  // En dropped on the completing cycle wins; qualification restarts after En returns.
  task automatic test_en_abort();
    i_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) en_a = 1'b0;
      if (k == 6) en_a = 1'b1;
      total++;
      if (r_a !== (k == 10) || q_a !== (k < 10)) begin
        bad++;
        $display("FAIL en_abort edge=%0d got R=%b Q=%b want R=%b Q=%b",
                 k, r_a, q_a, (k == 10), (k < 10));
      end
    end
  endtask

  // EV_W=2: reset during first QUAL_HI discards it, then four rises count 1,2,3,0.
  task automatic test_wrap();
    logic [1:0] exp_ev;
    exp_ev = 2'd0;
    for (int p = 0; p < 5; p++) begin
      i_b = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (p == 0 && k == 4) rst_b = 1'b1;
        if (p == 0 && k == 5) rst_b = 1'b0;
        total++;
        if (s_b !== (p > 0 && k == 6) || r_b !== 1'b0) begin
          bad++;
          $display("FAIL wrap_hi p=%0d edge=%0d got S=%b R=%b want S=%b R=0",
                   p, k, s_b, r_b, (p > 0 && k == 6));
        end
      end
      if (p > 0) exp_ev = exp_ev + 2'd1;
      total++;
      if (ev_b !== exp_ev) begin
        bad++;
        $display("FAIL wrap_ev p=%0d got=%0d want=%0d", p, ev_b, exp_ev);
      end
      i_b = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        total++;
        if (r_b !== (p > 0 && k == 6) || s_b !== 1'b0) begin
          bad++;
          $display("FAIL wrap_lo p=%0d edge=%0d got R=%b S=%b want R=%b S=0",
                   p, k, r_b, s_b, (p > 0 && k == 6));
        end
      end
    end
  endtask

  // DEBOUNCE_CYC=1, SYNC_STAGES=3: direct IDLE-to-IDLE path, latency 4.
  task automatic test_fast();
    i_c = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (s_c !== (k == 4) || q_c !== (k >= 4) || qb_c !== (k < 4)) begin
        bad++;
        $display("FAIL fast_rise edge=%0d got S=%b Q=%b Qb=%b want S=%b Q=%b",
                 k, s_c, q_c, qb_c, (k == 4), (k >= 4));
      end
    end
    i_c = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (r_c !== (k == 4) || q_c !== (k < 4)) begin
        bad++;
        $display("FAIL fast_fall edge=%0d got R=%b Q=%b want R=%b Q=%b",
                 k, r_c, q_c, (k == 4), (k < 4));
      end
    end
    total++;
    if (ev_c !== 8'd1) begin
      bad++;
      $display("FAIL fast_ev got=%0d want=1", ev_c);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_enable();
    test_en_abort();
    test_wrap();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
